fifo_mp: RTL

Multi-port, first-word-fall-through FIFO. It is the parametrised successor to the single-port `fifo`. Each cycle it accepts up to WR_PORTS pushes and RD_PORTS pops, and exposes the RD_PORTS oldest entries at once. It adds programmable almost-thresholds, an occupancy count and a synchronous flush. It sits between fetch/decode and dispatch in the core, where superscalar stages produce and consume several entries per cycle.

---
 rtl/fifo_pkg.sv | 26 ++
 rtl/fifo_mp_storage.sv | 44 ++++
 rtl/fifo_mp.sv | 133 +++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared helpers for the multi-port FIFO: lane-request decoding and circular pointer math.
package fifo_pkg;

  localparam int LANE_VEC_W = 32;
  typedef logic [LANE_VEC_W-1:0] lane_vec_t;

  // Length of the unbroken run of ones starting at bit 0; anything past the first zero is ignored.
  function automatic int thermo_len(input lane_vec_t vec, input int lanes);
    int   n;
    logic run;
    n   = 0;
    run = 1'b1;
    for (int i = 0; i < LANE_VEC_W; i++) begin
      if (i < lanes) begin
        run = run & vec[i];
        if (run) n++;
      end
    end
    return n;
  endfunction

  function automatic int ptr_add(input int ptr, input int n, input int depth);
    return (ptr + n) % depth;
  endfunction

endpackage

// File: rtl/fifo_mp_storage.sv
// Register array for fifo_mp: WR_PORTS write lanes at wr_ptr+i, RD_PORTS combinational read lanes at rd_ptr+i.
module fifo_mp_storage
  import fifo_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 16,
  parameter int WR_PORTS = 2,
  parameter int RD_PORTS = 2
) (
  input  logic                          clk,
  input  logic [$clog2(DEPTH)-1:0]      wr_ptr,
  input  logic [WR_PORTS-1:0]           wr_lane_en,
  input  logic [WR_PORTS*WIDTH-1:0]     wr_data,
  input  logic [$clog2(DEPTH)-1:0]      rd_ptr,
  output logic [RD_PORTS*WIDTH-1:0]     rd_data
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    for (int i = 0; i < WR_PORTS; i++) begin
      if (wr_lane_en[i]) begin
        mem_d[PTR_W'(ptr_add(int'(wr_ptr), i, DEPTH))] = wr_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Contents are deliberately left unreset; occupancy tracking makes stale data invisible.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < RD_PORTS; i++) begin
      rd_data[i*WIDTH +: WIDTH] = mem_q[PTR_W'(ptr_add(int'(rd_ptr), i, DEPTH))];
    end
  end

endmodule

// File: rtl/fifo_mp.sv
// Multi-port first-word-fall-through FIFO with all-or-nothing push/pop, flush and status flags.
// Define FIFO_MP_ERR_EN to enable the sticky overflow/underflow flags and lane-request assertions.
module fifo_mp
  import fifo_pkg::*;
#(
  parameter int FIFO_WIDTH = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int WR_PORTS   = 2,
  parameter int RD_PORTS   = 2,
  parameter int AF_MARGIN  = 2,
  parameter int AE_MARGIN  = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               flush,
  input  logic [WR_PORTS-1:0]                wr_en,
  input  logic [WR_PORTS*FIFO_WIDTH-1:0]     data_in,
  input  logic [RD_PORTS-1:0]                rd_en,
  output logic [RD_PORTS*FIFO_WIDTH-1:0]     data_out,
  output logic [RD_PORTS-1:0]                valid_out,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    count,
  output logic                               empty,
  output logic                               almost_empty,
  output logic                               full,
  output logic                               almost_full,
  output logic                               err_overflow,
  output logic                               err_underflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [PTR_W-1:0]    head_q, head_d;
  logic [PTR_W-1:0]    tail_q, tail_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [WR_PORTS-1:0] wr_lane_en;
  logic                push_ok, pop_ok;
  int                  npush, npop, push_n, pop_n;

  // Acceptance only looks at the registered count: same-cycle pops/pushes are never credited.
  always_comb begin
    npush   = thermo_len(lane_vec_t'(wr_en), WR_PORTS);
    npop    = thermo_len(lane_vec_t'(rd_en), RD_PORTS);
    push_ok = npush <= (FIFO_DEPTH - int'(count_q));
    pop_ok  = npop <= int'(count_q);
    push_n  = push_ok ? npush : 0;
    pop_n   = pop_ok ? npop : 0;

    for (int i = 0; i < WR_PORTS; i++) begin
      wr_lane_en[i] = !flush && (i < push_n);
    end

    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = PTR_W'(ptr_add(int'(head_q), pop_n, FIFO_DEPTH));
      tail_d  = PTR_W'(ptr_add(int'(tail_q), push_n, FIFO_DEPTH));
      count_d = CNT_W'(int'(count_q) + push_n - pop_n);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  fifo_mp_storage #(
    .WIDTH    (FIFO_WIDTH),
    .DEPTH    (FIFO_DEPTH),
    .WR_PORTS (WR_PORTS),
    .RD_PORTS (RD_PORTS)
  ) u_storage (
    .clk        (clk),
    .wr_ptr     (tail_q),
    .wr_lane_en (wr_lane_en),
    .wr_data    (data_in),
    .rd_ptr     (head_q),
    .rd_data    (data_out)
  );

  always_comb begin
    for (int i = 0; i < RD_PORTS; i++) begin
      valid_out[i] = int'(count_q) > i;
    end
  end

  assign count        = count_q;
  assign empty        = (count_q == '0);
  assign full         = (int'(count_q) == FIFO_DEPTH);
  assign almost_empty = (int'(count_q) <= AE_MARGIN);
  assign almost_full  = ((FIFO_DEPTH - int'(count_q)) <= AF_MARGIN);

`ifdef FIFO_MP_ERR_EN
  logic err_ovf_q, err_ovf_d;
  logic err_unf_q, err_unf_d;

  always_comb begin
    err_ovf_d = err_ovf_q | (!flush && !push_ok);
    err_unf_d = err_unf_q | (!flush && !pop_ok);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_ovf_q <= 1'b0;
      err_unf_q <= 1'b0;
    end else begin
      err_ovf_q <= err_ovf_d;
      err_unf_q <= err_unf_d;
    end
  end

  assign err_overflow  = err_ovf_q;
  assign err_underflow = err_unf_q;

  a_wr_thermo : assert property (@(posedge clk) disable iff (rst)
    (wr_en & (wr_en + 1'b1)) == '0);
  a_rd_thermo : assert property (@(posedge clk) disable iff (rst)
    (rd_en & (rd_en + 1'b1)) == '0);
`else
  assign err_overflow  = 1'b0;
  assign err_underflow = 1'b0;
`endif

endmodule
